// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter: FSM state encoding and
// the bit-period computation derived from clock frequency and baud rate.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } uart_state_e;

  // Integer division: any fractional remainder of the bit period is dropped.
  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses o_bit_done for one
// cycle on the last count. i_clear holds the count at zero.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst_,
  input  logic i_clear,
  output logic o_bit_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last     = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign o_bit_done = w_last;

  // Wrapping on the last count restarts every bit period at zero.
  always_ff @(posedge clk) begin
    if (rst_ || i_clear || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter, 8N1 by default; defining UART_TX_PARITY_EN inserts an
// even-parity bit between the data bits and the stop bit.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic        clk,
  input  logic        rst_,
  input  logic        tx_start,
  input  logic [7:0]  tx_data,
  output logic        tx_serial,
  output logic        tx_busy,
  output uart_state_e o_dbg_state
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_rate
      $error("uart_tx_core: CLKS_PER_BIT must be at least 2");
    end
  endgenerate

  uart_state_e r_state;
  logic [7:0]  r_data;
  logic [2:0]  r_idx;
  logic        r_serial;
  logic        r_busy;
  logic        w_bit_done;
  logic        w_clear;
  logic [2:0]  w_next_idx;

  assign w_clear    = (r_state == S_IDLE);
  assign w_next_idx = r_idx + 3'd1;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk       (clk),
    .rst_      (rst_),
    .i_clear   (w_clear),
    .o_bit_done(w_bit_done)
  );

  // Handshake: a request is accepted on any rising edge where tx_start=1 and
  // tx_busy=0; tx_data is captured on that edge and requests are ignored
  // until tx_busy falls again.
  always_ff @(posedge clk) begin
    if (rst_) begin
      r_state  <= S_IDLE;
      r_data   <= 8'h00;
      r_idx    <= 3'd0;
      r_serial <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_serial <= 1'b1;
          r_busy   <= 1'b0;
          r_idx    <= 3'd0;
          if (tx_start) begin
            r_data   <= tx_data;
            r_state  <= S_START;
            r_serial <= 1'b0;
            r_busy   <= 1'b1;
          end
        end
        S_START: begin
          if (w_bit_done) begin
            r_state  <= S_DATA;
            r_idx    <= 3'd0;
            r_serial <= r_data[0];
          end
        end
        S_DATA: begin
          if (w_bit_done) begin
            if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              r_state  <= S_PARITY;
              r_serial <= ^r_data;
`else
              r_state  <= S_STOP;
              r_serial <= 1'b1;
`endif
            end else begin
              r_idx    <= w_next_idx;
              r_serial <= r_data[w_next_idx];
            end
          end
        end
        S_PARITY: begin
          if (w_bit_done) begin
            r_state  <= S_STOP;
            r_serial <= 1'b1;
          end
        end
        S_STOP: begin
          if (w_bit_done) begin
            r_state  <= S_IDLE;
            r_serial <= 1'b1;
            r_busy   <= 1'b0;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_serial <= 1'b1;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign tx_serial   = r_serial;
  assign tx_busy     = r_busy;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed-plus-random bench for uart_tx_core: each frame is compared
// against a bit list built from the byte (start, LSB-first data, parity, stop).
module tb_uart_tx_core;
  import uart_pkg::*;

  localparam int CPB = 50_000_000 / 115200;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic        clk;
  logic        rst_;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_serial;
  logic        tx_busy;
  uart_state_e dbg_state;

  int checks = 0;
  int errors = 0;

  uart_tx_core dut (
    .clk        (clk),
    .rst_       (rst_),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_serial  (tx_serial),
    .tx_busy    (tx_busy),
    .o_dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void build_frame(input logic [7:0] d, output logic exp_q[$]);
    exp_q = {};
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    exp_q.push_back(^d);
`endif
    exp_q.push_back(1'b1);
  endfunction

  // Requests a frame of d, then checks start/middle/end of every bit period,
  // the busy length and the idle cycle after it. poke_at >= 0 injects an
  // ignored request of poke_d at that cycle; keep_start leaves tx_start high.
  task automatic send_and_check(input logic [7:0] d, input bit keep_start,
                                input int poke_at, input logic [7:0] poke_d);
    logic exp_q[$];
    int   busy_cnt;
    int   b;
    int   r;
    build_frame(d, exp_q);
    tx_data  = d;
    tx_start = 1'b1;
    tick();
    if (!keep_start) tx_start = 1'b0;
    busy_cnt = 0;
    for (int k = 0; k < NBITS * CPB; k++) begin
      b = k / CPB;
      r = k % CPB;
      if (tx_busy) busy_cnt++;
      if (r == 0 || r == CPB / 2 || r == CPB - 1)
        check($sformatf("byte%02h_bit%0d_r%0d", d, b, r), 32'(tx_serial), 32'(exp_q[b]));
      tx_data = 8'($urandom);
      if (k == poke_at) begin
        tx_start = 1'b1;
        tx_data  = poke_d;
      end else if (k == poke_at + 1 && !keep_start) begin
        tx_start = 1'b0;
      end
      tick();
    end
    check($sformatf("byte%02h_busy_len", d), 32'(busy_cnt), 32'(NBITS * CPB));
    check($sformatf("byte%02h_idle_line", d), 32'(tx_serial), 32'd1);
    check($sformatf("byte%02h_idle_busy", d), 32'(tx_busy), 32'd0);
  endtask

  initial begin
    logic [7:0] rnd;
    rst_     = 1'b1;
    tx_start = 1'b1;
    tx_data  = 8'hA5;

    // Reset dominates a pending request.
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst_line_%0d", i), 32'(tx_serial), 32'd1);
      check($sformatf("rst_busy_%0d", i), 32'(tx_busy), 32'd0);
    end
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    rst_     = 1'b0;
    tx_start = 1'b0;
    tick();
    check("post_rst_line", 32'(tx_serial), 32'd1);
    check("post_rst_busy", 32'(tx_busy), 32'd0);

    send_and_check(8'hA5, 1'b0, -10, 8'h00);
    tick();
    send_and_check(8'hA5, 1'b0, 1000, 8'h3C);
    tick();

    // Held request: frames separated by exactly one idle cycle.
    send_and_check(8'h00, 1'b1, -10, 8'h00);
    send_and_check(8'hFF, 1'b0, -10, 8'h00);
    tick();

    // Reset during data bit 3 (frame bit index 4) aborts the frame.
    tx_data  = 8'hC3;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    for (int k = 0; k < 4 * CPB + 100; k++) tick();
    rst_ = 1'b1;
    tick();
    check("abort_line", 32'(tx_serial), 32'd1);
    check("abort_busy", 32'(tx_busy), 32'd0);
    rst_ = 1'b0;
    tick();
    check("abort_idle_busy", 32'(tx_busy), 32'd0);
    send_and_check(8'h5A, 1'b0, -10, 8'h00);
    tick();

    send_and_check(8'h07, 1'b0, -10, 8'h00);
    tick();

    for (int n = 0; n < 3; n++) begin
      rnd = 8'($urandom);
      send_and_check(rnd, 1'($urandom_range(0, 1)), -10, 8'h00);
    end
    tx_start = 1'b0;
    tick();
    tick();
    check("final_idle_busy", 32'(tx_busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_core.md
UART_TX_CORE -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, serial bit rate in bit/s.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst_  input  1  reset; synchronous and active-high (port name fixed by codebase convention despite trailing underscore).
REQ-005 tx_start  input  1  transmit request, sampled every clock.
REQ-006 tx_data  input  8  byte to transmit; captured when a request is accepted.
REQ-007 tx_serial  output  1  serial line; idles high; driven from a register.
REQ-008 tx_busy  output  1  high while a frame is in progress; driven from a register.

Function
REQ-009 Bit period SHALL be CLKS_PER_BIT = CLK_FREQ / BAUD_RATE (integer division), i.e. 434 cycles at defaults.
REQ-010 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1).
REQ-011 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-012 IDLE: tx_serial=1, tx_busy=0; if tx_start=1 at a rising edge, latch tx_data and go to START.
REQ-013 The cycle after acceptance, tx_serial SHALL be 0 and tx_busy SHALL be 1 (one-cycle latency).
REQ-014 START, each DATA bit and STOP SHALL each be held for exactly CLKS_PER_BIT cycles.
REQ-015 DATA SHALL use a 3-bit index 0..7; after bit 7's period, go to STOP.
REQ-016 After STOP's period, return to IDLE; tx_busy SHALL be high for exactly 10*CLKS_PER_BIT cycles per frame (4340 at defaults).
REQ-017 tx_start while tx_busy=1 SHALL be ignored; tx_data changes during a frame SHALL NOT affect it.
REQ-018 tx_start held high continuously SHALL produce back-to-back frames separated by exactly one idle cycle (tx_serial=1, tx_busy=0).
REQ-019 Bit-period counter width SHALL be $clog2(CLKS_PER_BIT); it SHALL restart at 0 on every bit transition.
REQ-020 Elaboration SHALL fail if CLKS_PER_BIT < 2.

Reset
REQ-021 While rst_=1 at a rising edge: state=IDLE, tx_serial=1, tx_busy=0, counters and bit index=0, data register=0.
REQ-022 Reset SHALL dominate tx_start; a reset mid-frame SHALL abort the frame, line high the next cycle.

Configuration
REQ-023 Macro UART_TX_PARITY_EN defined: a PARITY state SHALL follow DATA, sending even parity (XOR of the 8 data bits) for one bit period; frame = 11 bits, tx_busy high 11*CLKS_PER_BIT cycles.
REQ-024 Macro UART_TX_PARITY_EN undefined: no PARITY state, 8N1 only.

Structure
REQ-025 Package uart_pkg SHALL hold the FSM state enum typedef (including PARITY) and a function computing CLKS_PER_BIT from CLK_FREQ and BAUD_RATE.
REQ-026 One sub-module uart_baud_gen SHALL provide the bit-period counter and a one-cycle bit_done pulse, with a clear input driven by the FSM.

Verification
REQ-027 Reset held 3 cycles with tx_start=1 -> tx_serial=1, tx_busy=0 throughout and one cycle after release.
REQ-028 tx_data=0xA5, 1-cycle tx_start pulse -> start bit 0, then data bits 1,0,1,0,0,1,0,1, then stop 1, all sampled mid-bit (cycle 217+434*k after start); tx_busy high 4340 cycles.
REQ-029 Pulse tx_start with 0x3C at cycle 1000 of a 0xA5 frame -> ignored; only 0xA5 appears on the line; tx_busy stays high without extension.
REQ-030 tx_start held high, tx_data=0x00 then 0xFF -> two frames with exactly one idle-high cycle between them.
REQ-031 Assert rst_ during data bit 3 -> tx_serial=1, tx_busy=0 the next cycle; a following 0x5A request transmits correctly.
REQ-032 With UART_TX_PARITY_EN: 0xA5 -> parity bit 0; 0x07 -> parity bit 1; tx_busy high 4774 cycles.
